branch_update_ctrl: RTL and testbench

- Sequences all writes into the branch predictor's prediction and target tables through a single write port.
- Buffers resolved-branch updates from MEM in a small FIFO and drains one per cycle when the port is free.
- Runs a table-invalidation walk on request (fence.i or context switch), clearing every index one per cycle.
- Sits between the MEM stage and the predictor's table write port. Also tells fetch to ignore predictions while tables are stale.

---
 rtl/branch_update_ctrl.sv | 200 ++++++++++++++++++++
 tb/tb_branch_update_ctrl.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_update_ctrl.sv
// -----------------------------------------------------------------------------
// branch_update_ctrl
//
// Owns the branch predictor's single table write port. Resolved-branch
// updates from MEM are buffered in a small FIFO and drained one per cycle
// whenever the port is free. An invalidation request (fence.i / context
// switch) flushes the FIFO and walks every table index, clearing it.
//
// Optional feature macro: BRANCH_UPDATE_STATS_EN
//   defined   : drop_cnt counts updates lost to a full FIFO (saturating).
//   undefined : drop_cnt is tied to 0.
//
// Ports
//   clk            clock
//   nrst           synchronous active-low reset
//   mem_branch     resolved branch/jump valid in MEM
//   mem_pc         PC of the resolved instruction
//   mem_taken      resolved direction
//   mem_target_res resolved target
//   inv_req        one-cycle request for a full table invalidate
//   wr_busy        predictor write port unavailable this cycle
//   wr_en          table write strobe
//   wr_idx         table index to write
//   wr_clear       write resets the entry (strong not-taken, target 0)
//   wr_taken       direction for the counter update (0 when clearing)
//   wr_target      target to store (0 when clearing)
//   inv_busy       walk in progress; fetch must predict not-taken
//   inv_done       one-cycle pulse when the walk completes
//   fifo_full      update FIFO full
//   drop_cnt       dropped-update count
// -----------------------------------------------------------------------------
module branch_update_ctrl #(
   parameter int BTB_BITS       = 5,
   parameter int UPD_DEPTH_BITS = 2
) (
   input  logic                clk,
   input  logic                nrst,
   input  logic                mem_branch,
   input  logic [31:0]         mem_pc,
   input  logic                mem_taken,
   input  logic [31:0]         mem_target_res,
   input  logic                inv_req,
   input  logic                wr_busy,
   output logic                wr_en,
   output logic [BTB_BITS-1:0] wr_idx,
   output logic                wr_clear,
   output logic                wr_taken,
   output logic [31:0]         wr_target,
   output logic                inv_busy,
   output logic                inv_done,
   output logic                fifo_full,
   output logic [15:0]         drop_cnt
);

   localparam int DEPTH = 1 << UPD_DEPTH_BITS;
   localparam logic [BTB_BITS-1:0] LAST_IDX = '1;

   typedef enum logic {IDLE, CLEAR} state_e;

   typedef struct packed {
      logic [BTB_BITS-1:0] idx;
      logic                taken;
      logic [31:0]         target;
   } upd_t;

   state_e                state_q, state_d;
   logic [BTB_BITS-1:0]   walk_q, walk_d;
   logic                  done_q, done_d;
   // One extra pointer bit distinguishes full (MSBs differ) from empty.
   logic [UPD_DEPTH_BITS:0] wptr_q, wptr_d, rptr_q, rptr_d;
   upd_t                  fifo_q [DEPTH];

   logic fifo_empty;
   logic pop;
   logic push;
   upd_t head;

   // Only the index bits of the PC reach the table.
   logic unused_pc;
   assign unused_pc = ^{mem_pc[31:BTB_BITS+2], mem_pc[1:0]};

   assign fifo_empty = (wptr_q == rptr_q);
   assign fifo_full  = (wptr_q[UPD_DEPTH_BITS] != rptr_q[UPD_DEPTH_BITS]) &&
                       (wptr_q[UPD_DEPTH_BITS-1:0] == rptr_q[UPD_DEPTH_BITS-1:0]);
   assign head       = fifo_q[rptr_q[UPD_DEPTH_BITS-1:0]];
   assign pop        = (state_q == IDLE) && !fifo_empty && !wr_busy;
   assign inv_done   = done_q;

   // NOTE: every signal written here gets a default first so no latch is inferred.
   always_comb begin
      state_d   = state_q;
      walk_d    = walk_q;
      wptr_d    = wptr_q;
      rptr_d    = rptr_q;
      done_d    = 1'b0;
      push      = 1'b0;
      wr_en     = 1'b0;
      wr_idx    = '0;
      wr_clear  = 1'b0;
      wr_taken  = 1'b0;
      wr_target = '0;
      inv_busy  = 1'b0;

      unique case (state_q)
         IDLE: begin
            wr_en = pop;
            if (pop) begin
               wr_idx    = head.idx;
               wr_taken  = head.taken;
               wr_target = head.target;
            end
            if (inv_req) begin
               // Queued updates describe the old context; throw them away,
               // along with any branch arriving this cycle.
               state_d = CLEAR;
               walk_d  = '0;
               wptr_d  = '0;
               rptr_d  = '0;
            end else begin
               if (pop) rptr_d = rptr_q + 1'b1;
               // A full FIFO still accepts a push when the head leaves this cycle.
               if (mem_branch && (!fifo_full || pop)) begin
                  push   = 1'b1;
                  wptr_d = wptr_q + 1'b1;
               end
            end
         end

         CLEAR: begin
            inv_busy = 1'b1;
            wr_clear = 1'b1;
            wr_en    = !wr_busy;
            wr_idx   = walk_q;
            if (inv_req) begin
               walk_d = '0;
            end else if (!wr_busy) begin
               if (walk_q == LAST_IDX) begin
                  state_d = IDLE;
                  walk_d  = '0;
                  done_d  = 1'b1;
               end else begin
                  walk_d = walk_q + 1'b1;
               end
            end
         end

         default: state_d = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of block ordering.
   always_ff @(posedge clk) begin
      if (!nrst) begin
         state_q <= IDLE;
         walk_q  <= '0;
         done_q  <= 1'b0;
         wptr_q  <= '0;
         rptr_q  <= '0;
      end else begin
         state_q <= state_d;
         walk_q  <= walk_d;
         done_q  <= done_d;
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
      end
   end

   // NOTE: FIFO storage is not reset; the pointers alone define which
   // entries are valid, so resetting the array would only cost flops.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_q[wptr_q[UPD_DEPTH_BITS-1:0]] <= '{idx:    mem_pc[BTB_BITS+1:2],
                                                taken:  mem_taken,
                                                target: mem_target_res};
      end
   end

`ifdef BRANCH_UPDATE_STATS_EN
   logic        drop;
   logic [15:0] drop_cnt_q;

   // A drop is a push refused by a full FIFO; branches discarded by an
   // invalidate or during the walk are not drops.
   assign drop = (state_q == IDLE) && !inv_req && mem_branch && fifo_full && !pop;

   always_ff @(posedge clk) begin
      if (!nrst) begin
         drop_cnt_q <= '0;
      end else if (drop && (drop_cnt_q != 16'hFFFF)) begin
         drop_cnt_q <= drop_cnt_q + 16'd1;
      end
   end

   assign drop_cnt = drop_cnt_q;
`else
   assign drop_cnt = '0;
`endif

endmodule

// File: tb/tb_branch_update_ctrl.sv
// -----------------------------------------------------------------------------
// Testbench for branch_update_ctrl. A queue-based model of the update FIFO
// and invalidation walk predicts every output each cycle; directed sequences
// add hand-computed expectations, followed by a randomized run.
// -----------------------------------------------------------------------------
module tb_branch_update_ctrl;

   logic        clk = 1'b0;
   logic        nrst;
   logic        mem_branch;
   logic [31:0] mem_pc;
   logic        mem_taken;
   logic [31:0] mem_target_res;
   logic        inv_req;
   logic        wr_busy;
   logic        wr_en;
   logic [4:0]  wr_idx;
   logic        wr_clear;
   logic        wr_taken;
   logic [31:0] wr_target;
   logic        inv_busy;
   logic        inv_done;
   logic        fifo_full;
   logic [15:0] drop_cnt;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   branch_update_ctrl dut (
      .clk            (clk),
      .nrst           (nrst),
      .mem_branch     (mem_branch),
      .mem_pc         (mem_pc),
      .mem_taken      (mem_taken),
      .mem_target_res (mem_target_res),
      .inv_req        (inv_req),
      .wr_busy        (wr_busy),
      .wr_en          (wr_en),
      .wr_idx         (wr_idx),
      .wr_clear       (wr_clear),
      .wr_taken       (wr_taken),
      .wr_target      (wr_target),
      .inv_busy       (inv_busy),
      .inv_done       (inv_done),
      .fifo_full      (fifo_full),
      .drop_cnt       (drop_cnt)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------------------------------------------------------- model
   typedef struct {
      int          idx;
      bit          tk;
      logic [31:0] tg;
   } ent_t;

   ent_t        q[$];
   bit          m_clear = 0;
   int          m_walk  = 0;
   bit          m_done  = 0;
   int          m_drops = 0;
   bit          model_on = 0;

   bit          e_en, e_clr, e_tk, e_busy, e_full;
   int          e_idx;
   logic [31:0] e_tg;
   int          e_drop;

   // Outputs are checked mid-cycle; inputs are stable there and are the
   // values the next rising edge will sample, so the model steps here too.
   always @(negedge clk) begin : compare_p
      e_en = 0; e_clr = 0; e_tk = 0; e_tg = 0; e_idx = 0; e_busy = 0;
      if (m_clear) begin
         e_busy = 1;
         e_clr  = 1;
         e_en   = !wr_busy;
         e_idx  = m_walk;
      end else begin
         e_en = (q.size() > 0) && !wr_busy;
         if (e_en) begin
            e_idx = q[0].idx;
            e_tk  = q[0].tk;
            e_tg  = q[0].tg;
         end
      end
      e_full = (q.size() == 4);
`ifdef BRANCH_UPDATE_STATS_EN
      e_drop = m_drops;
`else
      e_drop = 0;
`endif
      if (model_on) begin
         check("wr_en",     wr_en,     e_en);
         check("wr_idx",    wr_idx,    e_idx);
         check("wr_clear",  wr_clear,  e_clr);
         check("wr_taken",  wr_taken,  e_tk);
         check("wr_target", wr_target, e_tg);
         check("inv_busy",  inv_busy,  e_busy);
         check("inv_done",  inv_done,  m_done);
         check("fifo_full", fifo_full, e_full);
         check("drop_cnt",  drop_cnt,  e_drop);
      end

      // advance the model to the state after the coming edge
      if (!nrst) begin
         q.delete();
         m_clear = 0; m_walk = 0; m_done = 0; m_drops = 0;
      end else begin
         m_done = 0;
         if (!m_clear) begin
            if (inv_req) begin
               q.delete();
               m_clear = 1;
               m_walk  = 0;
            end else begin
               if (e_en) void'(q.pop_front());
               if (mem_branch) begin
                  if (q.size() < 4)
                     q.push_back('{idx: (mem_pc >> 2) % 32, tk: mem_taken, tg: mem_target_res});
                  else if (m_drops < 65535)
                     m_drops++;
               end
            end
         end else begin
            if (inv_req) m_walk = 0;
            else if (e_en) begin
               if (m_walk == 31) begin
                  m_clear = 0;
                  m_walk  = 0;
                  m_done  = 1;
               end else begin
                  m_walk++;
               end
            end
         end
      end
   end

   // -------------------------------------------------------------- stimulus
   // Apply one cycle of inputs just after a rising edge, return mid-cycle.
   task automatic cyc(input bit rst_n, input bit mb, input logic [31:0] pc, input bit tk,
                      input logic [31:0] tg, input bit inv, input bit busy);
      @(posedge clk);
      #1;
      nrst           = rst_n;
      mem_branch     = mb;
      mem_pc         = pc;
      mem_taken      = tk;
      mem_target_res = tg;
      inv_req        = inv;
      wr_busy        = busy;
      @(negedge clk);
   endtask

   task automatic idle(input bit busy);
      cyc(1, 0, 32'h0, 0, 32'h0, 0, busy);
   endtask

   int  cnt;
   int  bad_wr;
   bit  seen;

   initial begin
      nrst = 0; mem_branch = 0; mem_pc = 0; mem_taken = 0;
      mem_target_res = 0; inv_req = 0; wr_busy = 0;

      // reset
      cyc(0, 0, 0, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 0, 0, 0);
      model_on = 1;
      check("rst_wr_en",     wr_en,     0);
      check("rst_inv_busy",  inv_busy,  0);
      check("rst_fifo_full", fifo_full, 0);
      check("rst_drop_cnt",  drop_cnt,  0);

      // single update: pc 0x48 -> index 18
      cyc(1, 1, 32'h48, 1, 32'h100, 0, 0);
      check("single_pre_en", wr_en, 0);
      idle(0);
      check("single_en",     wr_en,     1);
      check("single_idx",    wr_idx,    18);
      check("single_taken",  wr_taken,  1);
      check("single_target", wr_target, 32'h100);
      idle(0);
      check("single_empty_after", wr_en, 0);

      // backpressure and drop
      for (int i = 0; i < 5; i++) begin
         cyc(1, 1, 32'(i * 4), i[0], 32'h1000 + 32'(i), 0, 1);
         if (i == 3) check("bp_not_full_yet", fifo_full, 0);
         if (i == 4) check("bp_full_after_4", fifo_full, 1);
      end
      idle(1);
      check("bp_still_full", fifo_full, 1);
`ifdef BRANCH_UPDATE_STATS_EN
      check("bp_drop_cnt", drop_cnt, 1);
`endif
      for (int i = 0; i < 4; i++) begin
         idle(0);
         check("bp_drain_en",  wr_en,  1);
         check("bp_drain_idx", wr_idx, i);
      end
      idle(0);
      check("bp_drained", wr_en, 0);

      // full walk
      cyc(1, 0, 0, 0, 0, 1, 0);
      for (int i = 0; i < 32; i++) begin
         idle(0);
         check("walk_busy",  inv_busy, 1);
         check("walk_clear", wr_clear, 1);
         check("walk_idx",   wr_idx,   i);
         check("walk_done0", inv_done, 0);
      end
      idle(0);
      check("walk_done",     inv_done, 1);
      check("walk_busy_end", inv_busy, 0);
      idle(0);
      check("walk_done_pulse", inv_done, 0);

      // invalidate with pending updates
      for (int i = 0; i < 3; i++) cyc(1, 1, 32'h40 + 32'(i * 4), 1, 32'h2000, 0, 1);
      cyc(1, 1, 32'h80, 1, 32'h3000, 1, 1);
      bad_wr = 0; seen = 0;
      for (int i = 0; i < 40 && !seen; i++) begin
         idle(0);
         if (wr_en && !wr_clear) bad_wr++;
         if (inv_done) seen = 1;
      end
      check("pend_done_seen",   seen,   1);
      check("pend_no_upd_wr",   bad_wr, 0);
      check("pend_fifo_empty",  wr_en,  0);
`ifdef BRANCH_UPDATE_STATS_EN
      check("pend_drop_kept", drop_cnt, 1);
`endif

      // restart at index 10, then 3 stalled cycles
      cyc(1, 0, 0, 0, 0, 1, 0);
      for (int i = 0; i < 10; i++) idle(0);
      cyc(1, 0, 0, 0, 0, 1, 0);
      check("restart_at10", wr_idx, 10);
      cnt = 0;
      for (int i = 0; i < 3; i++) begin
         idle(1);
         check("restart_idx0", wr_idx, 0);
         check("restart_stall", wr_en, 0);
         if (inv_busy) cnt++;
      end
      seen = 0;
      for (int i = 0; i < 100 && !seen; i++) begin
         idle(0);
         if (inv_busy) cnt++;
         if (inv_done) seen = 1;
      end
      check("restart_done_seen", seen, 1);
      check("restart_duration",  cnt,  35);

      // reset mid-walk at index 7
      cyc(1, 0, 0, 0, 0, 1, 0);
      for (int i = 0; i < 7; i++) idle(0);
      cyc(0, 0, 0, 0, 0, 0, 0);
      check("rstwalk_idx7", wr_idx, 7);
      idle(0);
      check("rstwalk_busy", inv_busy, 0);
      check("rstwalk_en",   wr_en,    0);
      check("rstwalk_done", inv_done, 0);
      idle(0);
      check("rstwalk_no_done", inv_done, 0);
      check("rstwalk_drop0",   drop_cnt, 0);

      // randomized traffic against the model
      for (int i = 0; i < 3000; i++) begin
         automatic bit rn  = ($urandom_range(0, 299) != 0);
         automatic bit mb  = ($urandom_range(0, 1) == 1);
         automatic bit inv = ($urandom_range(0, 149) == 0);
         automatic bit bsy = ($urandom_range(0, 99) < ((i / 200) % 2 == 1 ? 80 : 25));
         cyc(rn, mb, $urandom, $urandom_range(0, 1) == 1, $urandom, inv, bsy);
      end
      idle(0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
